// File: rtl/rmii_frame_tx.sv
// RMII transmitter: on each accepted start, sends one Ethernet II frame
// (preamble/SFD, fixed header, sequence payload, CRC-32 FCS), then an inter-frame gap.
module rmii_frame_tx #(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          PAYLOAD_LEN = 46,
  parameter int          IFG_CYCLES  = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [1:0]  txd,
  output logic        tx_en,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int PLEN = (PAYLOAD_LEN < 46) ? 46 : PAYLOAD_LEN;

  localparam logic [10:0] PRE_LAST = 11'd7;
  localparam logic [10:0] HDR_LAST = 11'd13;
  localparam logic [10:0] PAY_LAST = 11'(PLEN - 1);
  localparam logic [10:0] FCS_LAST = 11'd3;
  localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_FCS  = 3'd4;
  localparam logic [2:0] S_IFG  = 3'd5;

  // Reflected CRC-32, two bits per step, bit 0 of the dibit first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [10:0] byte_q, byte_d;
  logic [1:0]  dib_q, dib_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        tx_en_q, tx_en_d;
  logic [1:0]  txd_q, txd_d;
  logic [10:0] last_b;
  logic [2:0]  nxt;
  logic [7:0]  cur_byte;

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    dib_d    = dib_q;
    crc_d    = crc_q;
    seq_d    = seq_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    last_b   = PRE_LAST;
    nxt      = S_HDR;
    cur_byte = 8'h00;

    case (state_q)
      S_HDR:   begin last_b = HDR_LAST; nxt = S_PAY; end
      S_PAY:   begin last_b = PAY_LAST; nxt = S_FCS; end
      S_FCS:   begin last_b = FCS_LAST; nxt = S_IFG; end
      default: ;
    endcase

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_PRE;
        byte_d  = '0;
        dib_d   = '0;
        crc_d   = 32'hFFFF_FFFF;
      end
      S_PRE, S_HDR, S_PAY, S_FCS: begin
        dib_d = dib_q + 2'd1;
        if (dib_q == 2'd3) begin
          if (byte_q == last_b) begin
            state_d = nxt;
            byte_d  = '0;
          end else begin
            byte_d = byte_q + 11'd1;
          end
        end
        // The dibit currently on the wire is folded into the CRC.
        if (state_q == S_HDR || state_q == S_PAY) crc_d = crc_dibit(crc_q, txd_q);
      end
      S_IFG: begin
        if (byte_q == IFG_LAST) begin
          state_d = S_IDLE;
          byte_d  = '0;
        end else begin
          byte_d = byte_q + 11'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IFG && byte_d == IFG_LAST) begin
      done_d = 1'b1;
      cnt_d  = cnt_q + 16'd1;
      seq_d  = seq_q + 8'd1;
    end

    // Output registers carry the dibit for the position being entered.
    case (state_d)
      S_PRE:   cur_byte = (byte_d == PRE_LAST) ? 8'hD5 : 8'h55;
      S_HDR:   cur_byte = 8'(HDR >> {4'd13 - byte_d[3:0], 3'b000});
      S_PAY:   cur_byte = seq_q + byte_d[7:0];
      S_FCS:   cur_byte = 8'(~crc_d >> {byte_d[1:0], 3'b000});
      default: ;
    endcase

    tx_en_d = (state_d == S_PRE) || (state_d == S_HDR) || (state_d == S_PAY) || (state_d == S_FCS);
    txd_d   = tx_en_d ? 2'(cur_byte >> {dib_d, 1'b0}) : 2'b00;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      dib_q   <= '0;
      seq_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      tx_en_q <= 1'b0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      dib_q   <= dib_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tx_en_q <= tx_en_d;
      txd_q   <= txd_d;
    end
  end

  // CRC is pure datapath; it is seeded on every accepted start.
  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign txd         = txd_q;
  assign tx_en       = tx_en_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_count = cnt_q;

endmodule
